morse_letter_decoder: RTL and testbench
=======================================

Name: morse_letter_decoder

Overview:
Upstream neighbour of the letter-to-seven-segment stage. Samples a single debounced Morse key and times each press and each gap. Classifies presses as dot or dash, collects up to 4 symbols, and on an inter-letter gap emits a 5-bit letter code (1=A … 26=Z, 0=blank/invalid). The held letter code drives the display stage directly.

Parameters:
MIN_MARK, 500000, press shorter than this many cycles is a glitch and is discarded (10 ms @ 50 MHz)
DASH_CYCLES, 10000000, press of at least this many cycles is a dash; shorter is a dot (200 ms)
GAP_CYCLES, 15000000, key-up time that terminates a letter (300 ms)
- Constraint: MIN_MARK < DASH_CYCLES, GAP_CYCLES > 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key  in  1  Morse key level, 1=pressed, asynchronous to clk
letter  out  5  last decoded letter code, held until next emit
letter_valid  out  1  one-cycle pulse when letter updates
err  out  1  high with a letter_valid pulse when the pattern was invalid or overflowed
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (sync, active-high, any state): letter=0, letter_valid=0, err=0, busy=0. Pattern, length and counter are cleared; FSM goes to IDLE; key_s history is cleared to 1.
- Synchronisation: key passes through a 2-flop synchroniser to key_s; all timing uses key_s.
- Press detection: rising edge of key_s (key_s=1, previous=0). A key held through reset is ignored until released and pressed again.
- Counter: one shared counter, width $clog2(max(DASH_CYCLES,GAP_CYCLES)+1), saturating.
- FSM states:
  - IDLE: on key_s rising edge → MARK, cnt=1.
  - MARK: cnt increments each cycle key_s=1. On key_s=0, classify L=cnt:
    - L<MIN_MARK: glitch, no symbol stored; go to IDLE if len=0, else SPACE with cnt restarted.
    - L<DASH_CYCLES: dot (0).
    - otherwise: dash (1).
    - Storing a symbol: pattern={pattern[2:0],sym}, len+1, then → SPACE with cnt=1.
    - If len is already 4, the symbol is not stored and the overflow flag is set.
  - SPACE: cnt increments while key_s=0. On key_s rising edge before cnt reaches GAP_CYCLES → MARK, cnt=1. When cnt==GAP_CYCLES → EMIT.
  - EMIT (one cycle):
    - letter ← lut(pattern,len); letter_valid=1.
    - err=1 if overflow or lut returns 0; letter=0 in those cases.
    - Clear pattern/len/overflow; → IDLE.
    - A key press landing in the EMIT cycle is detected in IDLE on the next cycle only if the edge persists; the bench must not rely on it.
- Latency: with key_s falling at cycle N, letter_valid is high in cycle N+GAP_CYCLES. Relative to the raw input this is +2 cycles.
- Holding: letter and err hold between emits; letter_valid is high for exactly one cycle.
- Encoding: first symbol is in bit len-1, last symbol in bit 0; dot=0, dash=1.
- Lookup table:
  - A.- B-... C-.-. D-.. E. F..-. G--. H.... I.. J.--- K-.- L.-.. M--
  - N-. O--- P.--. Q--.- R.-. S... T- U..- V...- W.-- X-..- Y-.-- Z--..
  - Any other (pattern,len) → 0.

Decomposition:
- Package morse_pkg:
  - constants SYM_DOT=0, SYM_DASH=1, MAX_SYMBOLS=4, LETTER_BLANK=5'd0
  - state enum {IDLE, MARK, SPACE, EMIT}
- Sub-module morse_lut: combinational, input pattern[3:0] and len[2:0], output letter[4:0]; purely the table above.
- The FSM, synchroniser and counter live in the top module.

Test Plan:
Bench parameters: MIN_MARK=2, DASH_CYCLES=8, GAP_CYCLES=12.
- Press 3 cycles, release 4, press 10, release 20 → after the gap, letter=1 (A), letter_valid pulses once, err=0, letter holds 1 afterwards.
- Press 10, gap 4, then dot/dot/dot (each 3 cycles, 4-cycle gaps), then release 20 → letter=2 (B). letter_valid occurs exactly 12 cycles after key_s falls on the final dot.
- Press 1 cycle (glitch), then release 20 → no letter_valid, FSM back to IDLE, busy=0. Then a 3-cycle press and 20-cycle release → letter=5 (E).
- Five dots → letter_valid with letter=0 and err=1. Then "-" (dash) → letter=20 (T), err=0.
- Pattern ..-- (valid length, no match) → letter=0, err=1.
- Assert rst for 1 cycle during MARK of a dash → all outputs 0 and no emit. With key still held through reset, no symbol is registered until release and a fresh press. Separately, a rst pulse coinciding with the EMIT cycle → letter=0, letter_valid=0.

Source files
------------

// File: rtl/morse_letter_decoder_pkg.sv
// Shared constants, widths and FSM state type for the Morse letter decoder.
package morse_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned PAT_W       = 4;
  localparam int unsigned LEN_W       = 3;
  localparam int unsigned MAX_SYMBOLS = 4;

  localparam logic                SYM_DOT      = 1'b0;
  localparam logic                SYM_DASH     = 1'b1;
  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/morse_letter_decoder_if.sv
// Key input and decoded-letter outputs of the Morse decoder.
// master = decoder side, slave = key source / letter consumer.
interface morse_letter_decoder_if;
  import morse_pkg::*;

  logic                key;
  logic [LETTER_W-1:0] letter;
  logic                letter_valid;
  logic                err;
  logic                busy;

  modport master (
    input  key,
    output letter,
    output letter_valid,
    output err,
    output busy
  );

  modport slave (
    output key,
    input  letter,
    input  letter_valid,
    input  err,
    input  busy
  );

endinterface

// File: rtl/morse_letter_decoder_lut.sv
// Maps a dot/dash pattern (first symbol in bit len-1) to a letter code, 0 if none.
module morse_lut
  import morse_pkg::*;
(
  input  logic [PAT_W-1:0]    i_pattern,
  input  logic [LEN_W-1:0]    i_len,
  output logic [LETTER_W-1:0] o_letter
);

  // Pure table lookup, qualified by symbol count
  always_comb begin
    o_letter = LETTER_BLANK;
    case (i_len)
      3'd1: begin
        case (i_pattern[0])
          1'b0: o_letter = 5'd5;   // E .
          1'b1: o_letter = 5'd20;  // T -
          default: o_letter = LETTER_BLANK;
        endcase
      end
      3'd2: begin
        case (i_pattern[1:0])
          2'b01: o_letter = 5'd1;  // A .-
          2'b00: o_letter = 5'd9;  // I ..
          2'b11: o_letter = 5'd13; // M --
          2'b10: o_letter = 5'd14; // N -.
          default: o_letter = LETTER_BLANK;
        endcase
      end
      3'd3: begin
        case (i_pattern[2:0])
          3'b100: o_letter = 5'd4;  // D -..
          3'b110: o_letter = 5'd7;  // G --.
          3'b101: o_letter = 5'd11; // K -.-
          3'b111: o_letter = 5'd15; // O ---
          3'b010: o_letter = 5'd18; // R .-.
          3'b000: o_letter = 5'd19; // S ...
          3'b001: o_letter = 5'd21; // U ..-
          3'b011: o_letter = 5'd23; // W .--
          default: o_letter = LETTER_BLANK;
        endcase
      end
      3'd4: begin
        case (i_pattern)
          4'b1000: o_letter = 5'd2;  // B -...
          4'b1010: o_letter = 5'd3;  // C -.-.
          4'b0010: o_letter = 5'd6;  // F ..-.
          4'b0000: o_letter = 5'd8;  // H ....
          4'b0111: o_letter = 5'd10; // J .---
          4'b0100: o_letter = 5'd12; // L .-..
          4'b0110: o_letter = 5'd16; // P .--.
          4'b1101: o_letter = 5'd17; // Q --.-
          4'b0001: o_letter = 5'd22; // V ...-
          4'b1001: o_letter = 5'd24; // X -..-
          4'b1011: o_letter = 5'd25; // Y -.--
          4'b1100: o_letter = 5'd26; // Z --..
          default: o_letter = LETTER_BLANK;
        endcase
      end
      default: o_letter = LETTER_BLANK;
    endcase
  end

endmodule

// File: rtl/morse_letter_decoder.sv
// Times Morse key presses/gaps, collects up to 4 symbols and emits a letter code.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int unsigned MIN_MARK    = 500000,
  parameter int unsigned DASH_CYCLES = 10000000,
  parameter int unsigned GAP_CYCLES  = 15000000
) (
  input  logic                          clk,
  input  logic                          rst,
  morse_letter_decoder_if.master        bus
);

  localparam int unsigned MAX_CYC = (DASH_CYCLES > GAP_CYCLES) ? DASH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_MARK);
  localparam logic [CNT_W-1:0] CNT_DASH = CNT_W'(DASH_CYCLES);
  // Last SPACE count before the gap completes; the emit lands on the GAP_CYCLES-th key-up cycle
  localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic                r_sync1;
  logic                r_key_s;
  logic                r_key_prev;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PAT_W-1:0]    r_pattern;
  logic [LEN_W-1:0]    r_len;
  logic                r_ovf;
  logic [LETTER_W-1:0] r_letter;
  logic                r_valid;
  logic                r_err;
  logic                r_busy;

  logic                w_rise;
  logic                w_sym;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [LETTER_W-1:0] w_lut_letter;

  assign w_rise    = r_key_s & ~r_key_prev;
  assign w_sym     = (r_cnt < CNT_DASH) ? SYM_DOT : SYM_DASH;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  morse_lut u_lut (
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_letter  (w_lut_letter)
  );

  // Two-flop synchroniser plus edge history; reset to 1 so a held key is not a press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_key_s    <= 1'b1;
      r_key_prev <= 1'b1;
    end else begin
      r_sync1    <= bus.key;
      r_key_s    <= r_sync1;
      r_key_prev <= r_key_s;
    end
  end

  // Mark/space timing FSM with symbol collection and registered letter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_letter  <= LETTER_BLANK;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MARK;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        MARK: begin
          if (r_key_s) begin
            r_cnt <= w_cnt_inc;
          end else if (r_cnt < CNT_MIN) begin
            // Glitch: drop it, but keep an in-progress letter alive
            if (r_len == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= SPACE;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            if (r_len == LEN_W'(MAX_SYMBOLS)) begin
              r_ovf <= 1'b1;
            end else begin
              r_pattern <= {r_pattern[PAT_W-2:0], w_sym};
              r_len     <= r_len + LEN_W'(1);
            end
            r_state <= SPACE;
            r_cnt   <= CNT_ONE;
          end
        end
        SPACE: begin
          if (r_cnt >= CNT_GAP_LAST) begin
            r_state <= EMIT;
            r_valid <= 1'b1;
            if (r_ovf || (w_lut_letter == LETTER_BLANK)) begin
              r_letter <= LETTER_BLANK;
              r_err    <= 1'b1;
            end else begin
              r_letter <= w_lut_letter;
              r_err    <= 1'b0;
            end
          end else if (w_rise) begin
            r_state <= MARK;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        EMIT: begin
          r_pattern <= '0;
          r_len     <= '0;
          r_ovf     <= 1'b0;
          r_cnt     <= '0;
          r_state   <= IDLE;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.letter       = r_letter;
  assign bus.letter_valid = r_valid;
  assign bus.err          = r_err;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Directed bench for morse_letter_decoder with short timing parameters.
module tb_morse_letter_decoder;

  localparam int unsigned MIN_MARK    = 2;
  localparam int unsigned DASH_CYCLES = 8;
  localparam int unsigned GAP_CYCLES  = 12;
  // Raw key fall to letter_valid: 2 synchroniser cycles plus the gap
  localparam int unsigned EMIT_LAT    = GAP_CYCLES + 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_valid = 0;
  int   last_valid_cyc = -1;
  int   n_checks = 0;
  int   n_fail = 0;

  morse_letter_decoder_if bus ();

  morse_letter_decoder #(
    .MIN_MARK    (MIN_MARK),
    .DASH_CYCLES (DASH_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count every cycle letter_valid is seen high
  always @(negedge clk) begin
    if (bus.letter_valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key_down(input int n);
    bus.key = 1'b1;
    tick(n);
  endtask

  task automatic key_up(input int n);
    bus.key = 1'b0;
    tick(n);
  endtask

  task automatic dot_sp();
    key_down(3);
    key_up(4);
  endtask

  task automatic dash_sp();
    key_down(10);
    key_up(4);
  endtask

  // Verify exactly one emit since n0 and the held outputs after it
  task automatic check_emit(input string tag, input int n0, input int exp_letter, input int exp_err);
    check({tag, "_pulses"}, n_valid - n0, 1);
    check({tag, "_letter"}, int'(bus.letter), exp_letter);
    check({tag, "_err"}, int'(bus.err), exp_err);
    check({tag, "_valid_low"}, int'(bus.letter_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int n0;
    int f;

    rst     = 1'b1;
    bus.key = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_letter", int'(bus.letter), 0);
    check("rst_valid", int'(bus.letter_valid), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    tick(4);

    // A = .-
    n0 = n_valid;
    dot_sp();
    key_down(10);
    key_up(20);
    check_emit("A", n0, 1, 0);
    tick(5);
    check("A_hold", int'(bus.letter), 1);

    // B = -... with latency measured from the final raw key fall
    n0 = n_valid;
    dash_sp();
    dot_sp();
    dot_sp();
    key_down(3);
    f = cyc;
    key_up(20);
    check_emit("B", n0, 2, 0);
    check("B_latency", last_valid_cyc - f, EMIT_LAT);

    // Single-cycle glitch is discarded entirely
    n0 = n_valid;
    key_down(1);
    key_up(20);
    check("glitch_no_emit", n_valid - n0, 0);
    check("glitch_busy", int'(bus.busy), 0);
    check("glitch_letter_hold", int'(bus.letter), 2);

    // E = .
    n0 = n_valid;
    key_down(3);
    key_up(20);
    check_emit("E", n0, 5, 0);

    // Five dots overflow the symbol buffer
    n0 = n_valid;
    repeat (4) dot_sp();
    key_down(3);
    key_up(20);
    check_emit("ovf", n0, 0, 1);

    // T = - recovers cleanly after overflow
    n0 = n_valid;
    key_down(10);
    key_up(20);
    check_emit("T", n0, 20, 0);

    // ..-- is four symbols but no letter
    n0 = n_valid;
    dot_sp();
    dot_sp();
    dash_sp();
    key_down(10);
    key_up(20);
    check_emit("nomatch", n0, 0, 1);

    // Reset in the middle of a dash, key held through it
    n0 = n_valid;
    bus.key = 1'b1;
    tick(6);
    check("mark_busy", int'(bus.busy), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_letter", int'(bus.letter), 0);
    check("mrst_err", int'(bus.err), 0);
    check("mrst_busy", int'(bus.busy), 0);
    tick(6);
    check("held_busy", int'(bus.busy), 0);
    key_up(20);
    check("held_no_emit", n_valid - n0, 0);
    check("held_idle", int'(bus.busy), 0);

    // Fresh press after reset decodes normally
    key_down(3);
    key_up(20);
    check_emit("E2", n0, 5, 0);

    // Reset landing on the emit edge suppresses it
    n0 = n_valid;
    key_down(3);
    bus.key = 1'b0;
    tick(EMIT_LAT - 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("erst_letter", int'(bus.letter), 0);
    check("erst_valid", int'(bus.letter_valid), 0);
    tick(10);
    check("erst_no_emit", n_valid - n0, 0);
    check("erst_busy", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
